// File: rtl/instruction_fetch_unit_pkg.sv
// Default sizing and fetch state encoding shared by the fetch unit, its interface and bench.
package instruction_fetch_unit_pkg;

  localparam int DRAM_ADDRESS_SIZE = 32;
  localparam int DRAM_WORD_SIZE    = 32;
  localparam int FETCH_FIFO_DEPTH  = 4;
  localparam logic [DRAM_ADDRESS_SIZE-1:0] FETCH_RESET_PC = '0;

  typedef enum logic [1:0] {
    RUN       = 2'b01,
    MISS_WAIT = 2'b10
  } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch unit boundary: icache CPU-side handshake, redirect input and decode-side instruction stream.
interface instruction_fetch_unit_if
  import instruction_fetch_unit_pkg::*;
#(
  parameter int ADDR_W = DRAM_ADDRESS_SIZE,
  parameter int WORD_W = DRAM_WORD_SIZE
) ();

  logic [ADDR_W-1:0] icache_address;
  logic              icache_valid;
  logic [WORD_W-1:0] icache_data_in;
  logic              icache_data_ready;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              dec_valid;
  logic [WORD_W-1:0] dec_instr;
  logic [ADDR_W-1:0] dec_pc;
  logic              dec_ready;

  modport master (
    output icache_address, icache_valid, dec_valid, dec_instr, dec_pc,
    input  icache_data_in, icache_data_ready, redirect_valid, redirect_pc, dec_ready
  );

  modport slave (
    input  icache_address, icache_valid, dec_valid, dec_instr, dec_pc,
    output icache_data_in, icache_data_ready, redirect_valid, redirect_pc, dec_ready
  );

endinterface

// File: rtl/instruction_fetch_unit_fetch_fifo.sv
// Count-tracked instruction buffer; head is visible the cycle after push, flush drops all entries.
// Pop on an empty buffer is ignored; the producer must not push when count == DEPTH.
module fetch_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  input  logic          flush,
  output logic [CW-1:0] count,
  output logic [W-1:0]  head
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_pop;

  assign do_pop = pop && (count != '0);
  assign head   = mem[rd_ptr];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      // storage is left as-is; only the bookkeeping restarts
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      if (push && !do_pop)      count <= count + CW'(1);
      else if (!push && do_pop) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// PC owner and icache requester feeding decode through fetch_fifo; hits deliver one instruction per cycle.
// The request address stays frozen during a miss; redirects seen then are parked until the line returns.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int                ADDR_W     = DRAM_ADDRESS_SIZE,
  parameter int                WORD_W     = DRAM_WORD_SIZE,
  parameter int                FIFO_DEPTH = FETCH_FIFO_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(FETCH_RESET_PC)
) (
  input  logic                      clock,
  input  logic                      reset,
  instruction_fetch_unit_if.master  bus
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  fetch_state_t             state;
  logic [ADDR_W-1:0]        pc;
  logic [ADDR_W-1:0]        pend_pc;
  logic                     pend_valid;
  logic [ADDR_W-1:0]        redirect_target;
  logic [CW-1:0]            count;
  logic                     push;
  logic                     pop;
  logic [ADDR_W+WORD_W-1:0] head;

  assign redirect_target   = {bus.redirect_pc[ADDR_W-1:2], 2'b00};
  assign bus.icache_address = pc;
  assign bus.icache_valid   = reset && ((state == MISS_WAIT) || (state == RUN && count != FULL));

  // a miss return is only kept when no redirect is parked or arriving
  assign push = bus.icache_valid && bus.icache_data_ready && !bus.redirect_valid
             && ((state == RUN) || !pend_valid);
  assign pop  = bus.dec_valid && bus.dec_ready;

  assign bus.dec_valid            = (count != '0);
  assign {bus.dec_pc, bus.dec_instr} = head;

  fetch_fifo #(
    .W     (ADDR_W + WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data ({pc, bus.icache_data_in}),
    .pop       (pop),
    .flush     (bus.redirect_valid),
    .count     (count),
    .head      (head)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= RUN;
      pc         <= RESET_PC;
      pend_valid <= 1'b0;
      pend_pc    <= '0;
    end else begin
      case (state)
        RUN: begin
          if (bus.redirect_valid) begin
            pc <= redirect_target;
          end else if (bus.icache_valid) begin
            if (bus.icache_data_ready) pc    <= pc + ADDR_W'(4);
            else                       state <= MISS_WAIT;
          end
        end
        MISS_WAIT: begin
          if (bus.redirect_valid) begin
            pend_valid <= 1'b1;
            pend_pc    <= redirect_target;
          end
          if (bus.icache_data_ready) begin
            state      <= RUN;
            pend_valid <= 1'b0;
            if (bus.redirect_valid) pc <= redirect_target;
            else if (pend_valid)    pc <= pend_pc;
            else                    pc <= pc + ADDR_W'(4);
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench: expected decode entries are queued at issue time and checked by an independent monitor.
module tb_instruction_fetch_unit;
  import instruction_fetch_unit_pkg::*;

  localparam int AW = 32;
  localparam int WW = 32;
  localparam logic [31:0] DATA_KEY = 32'hCAFE_0000;

  logic clock  = 1'b0;
  logic reset  = 1'b1;
  logic hit_en = 1'b0;
  int   n_chk  = 0;
  int   n_fail = 0;
  logic [63:0] exp_q [$];

  instruction_fetch_unit_if #(.ADDR_W(AW), .WORD_W(WW)) bus ();

  instruction_fetch_unit #(
    .ADDR_W     (AW),
    .WORD_W     (WW),
    .FIFO_DEPTH (4),
    .RESET_PC   (32'h0)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // icache model: word content is a keyed function of its address, ready is test-controlled
  assign bus.icache_data_in    = bus.icache_address ^ DATA_KEY;
  assign bus.icache_data_ready = hit_en;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (reset && bus.dec_valid && bus.dec_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL dec_unexpected: got pc %h instr %h, expected no entry", bus.dec_pc, bus.dec_instr);
      end else begin
        check("dec_entry", {bus.dec_pc, bus.dec_instr}, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_fetch(input string name, input logic [31:0] addr, input logic vld);
    @(negedge clock);
    check({name, "_addr"}, 64'(bus.icache_address), 64'(addr));
    check({name, "_vld"}, 64'(bus.icache_valid), 64'(vld));
  endtask

  task automatic hit_cycle(input logic [31:0] addr);
    chk_fetch("hit", addr, 1'b1);
    exp_q.push_back({addr, addr ^ DATA_KEY});
    tick();
  endtask

  task automatic miss_cycle(input logic [31:0] addr);
    chk_fetch("miss", addr, 1'b1);
    tick();
  endtask

  task automatic drain_and_reset();
    bus.dec_ready      = 1'b1;
    bus.redirect_valid = 1'b0;
    hit_en             = 1'b0;
    repeat (6) tick();
    check("sb_drained", 64'(exp_q.size()), 64'd0);
    reset = 1'b0;
    exp_q.delete();
    repeat (2) tick();
    reset = 1'b1;
  endtask

  task automatic chk_reset_outputs(input string name);
    check({name, "_ic_vld"}, 64'(bus.icache_valid), 64'd0);
    check({name, "_ic_addr"}, 64'(bus.icache_address), 64'd0);
    check({name, "_dec_vld"}, 64'(bus.dec_valid), 64'd0);
    check({name, "_dec_pc"}, 64'(bus.dec_pc), 64'd0);
    check({name, "_dec_instr"}, 64'(bus.dec_instr), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

  initial begin
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.dec_ready      = 1'b1;
    #2 reset = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk_reset_outputs("reset");

    // sequential hits, then a 5-cycle miss at 0x10
    tick();
    reset  = 1'b1;
    hit_en = 1'b1;
    for (int i = 0; i < 4; i++) hit_cycle(32'(i * 4));
    hit_en = 1'b0;
    for (int i = 0; i < 5; i++) miss_cycle(32'h10);
    hit_en = 1'b1;
    hit_cycle(32'h10);
    hit_en = 1'b0;
    chk_fetch("after_miss", 32'h14, 1'b1);
    tick();
    drain_and_reset();

    // decode stalled: buffer fills, one pop admits exactly one more fetch
    bus.dec_ready = 1'b0;
    hit_en        = 1'b1;
    for (int i = 0; i < 4; i++) hit_cycle(32'(i * 4));
    for (int i = 0; i < 2; i++) begin
      chk_fetch("full_stall", 32'h10, 1'b0);
      check("full_head_pc", 64'(bus.dec_pc), 64'd0);
      tick();
    end
    bus.dec_ready = 1'b1;
    chk_fetch("pop_cycle", 32'h10, 1'b0);
    tick();
    bus.dec_ready = 1'b0;
    hit_cycle(32'h10);
    chk_fetch("refull", 32'h14, 1'b0);
    tick();
    chk_fetch("refull2", 32'h14, 1'b0);
    tick();
    drain_and_reset();

    // redirect in RUN with three entries buffered
    bus.dec_ready = 1'b0;
    hit_en        = 1'b1;
    for (int i = 0; i < 3; i++) hit_cycle(32'(i * 4));
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h203;
    chk_fetch("redirect_cycle", 32'hC, 1'b1);
    exp_q.delete();
    tick();
    bus.redirect_valid = 1'b0;
    bus.dec_ready      = 1'b1;
    chk_fetch("redirect_target", 32'h200, 1'b1);
    check("flush_dec_vld", 64'(bus.dec_valid), 64'd0);
    exp_q.push_back({32'h200, 32'h200 ^ DATA_KEY});
    tick();
    drain_and_reset();

    // redirect two cycles into a miss at 0x24
    bus.dec_ready = 1'b1;
    hit_en        = 1'b1;
    for (int i = 0; i < 9; i++) hit_cycle(32'(i * 4));
    hit_en = 1'b0;
    miss_cycle(32'h24);
    miss_cycle(32'h24);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h80;
    miss_cycle(32'h24);
    bus.redirect_valid = 1'b0;
    miss_cycle(32'h24);
    miss_cycle(32'h24);
    hit_en = 1'b1;
    chk_fetch("miss_return", 32'h24, 1'b1);
    tick();
    bus.dec_ready = 1'b0;
    chk_fetch("resume_target", 32'h80, 1'b1);
    tick();
    hit_en = 1'b0;
    chk_fetch("after_resume", 32'h84, 1'b1);
    check("first_dec_pc", 64'(bus.dec_pc), 64'h80);
    check("first_dec_instr", 64'(bus.dec_instr), 64'(32'h80 ^ DATA_KEY));
    tick();

    // asynchronous reset in the middle of the miss at 0x84
    #2 reset = 1'b0;
    #1 chk_reset_outputs("async_reset");
    exp_q.delete();
    repeat (2) tick();
    reset         = 1'b1;
    hit_en        = 1'b1;
    bus.dec_ready = 1'b1;
    hit_cycle(32'h0);
    hit_cycle(32'h4);
    hit_en = 1'b0;
    chk_fetch("restart", 32'h8, 1'b1);
    repeat (4) tick();
    check("final_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
